// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with programmable almost flags, occupancy output,
// sticky error flags and a selectable registered / first-word-fall-through read port.
module param_sync_fifo #(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 7,
  parameter int AE_THRESH = 1,
  parameter int FWFT      = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     rd_en,
  input  logic                     clr_err,
  output logic [DATA_W-1:0]        data_out,
  output logic                     rd_valid,
  output logic                     wr_ack,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     ovf_sticky,
  output logic                     udf_sticky,
  output logic                     full,
  output logic                     empty,
  output logic                     almostfull,
  output logic                     almostempty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_ack_q, wr_ack_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          ovf_sticky_q, ovf_sticky_d;
  logic          udf_sticky_q, udf_sticky_d;

  logic wr_ok;
  logic rd_ok;

  // Both requests are judged on the pre-edge occupancy, independently of each other.
  assign wr_ok = wr_en && (count_q != DEPTH_C);
  assign rd_ok = rd_en && (count_q != '0);

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    wr_ack_d     = wr_ok;
    overflow_d   = wr_en && !wr_ok;
    underflow_d  = rd_en && !rd_ok;
    ovf_sticky_d = overflow_d || (ovf_sticky_q && !clr_err);
    udf_sticky_d = underflow_d || (udf_sticky_q && !clr_err);

    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (wr_ok && !rd_ok) begin
      count_d = count_q + 1'b1;
    end else if (rd_ok && !wr_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      wr_ack_q     <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      ovf_sticky_q <= 1'b0;
      udf_sticky_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      wr_ack_q     <= wr_ack_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      ovf_sticky_q <= ovf_sticky_d;
      udf_sticky_q <= udf_sticky_d;
    end
  end

  // Storage carries no reset; a reset simply rewinds the pointers.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is presented directly; forced to zero while empty so stale storage never leaks.
    assign data_out = empty ? '0 : mem_q[rd_ptr_q];
    assign rd_valid = !empty;
  end else begin : g_reg
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              rd_valid_q, rd_valid_d;

    always_comb begin
      data_out_d = data_out_q;
      rd_valid_d = rd_ok;
      if (rd_ok) begin
        data_out_d = mem_q[rd_ptr_q];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        data_out_q <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        data_out_q <= data_out_d;
        rd_valid_q <= rd_valid_d;
      end
    end

    assign data_out = data_out_q;
    assign rd_valid = rd_valid_q;
  end

  assign wr_ack      = wr_ack_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;
  assign ovf_sticky  = ovf_sticky_q;
  assign udf_sticky  = udf_sticky_q;
  assign count       = count_q;
  assign full        = (count_q == DEPTH_C);
  assign empty       = (count_q == '0);
  assign almostfull  = (count_q >= AF_C);
  assign almostempty = (count_q <= AE_C);

  a_count_bound: assert property (@(posedge clk) count_q <= DEPTH_C);
  a_flag_consistency: assert property (@(posedge clk)
    !(full && empty) && (!full || almostfull) && (!empty || almostempty));
  a_wr_ptr_step: assert property (@(posedge clk)
    (!rst && wr_ok) |=> (wr_ptr_q == $past(wr_ptr_q) + 1'b1));
  a_rd_ptr_step: assert property (@(posedge clk)
    (!rst && rd_ok) |=> (rd_ptr_q == $past(rd_ptr_q) + 1'b1));
  a_count_stable: assert property (@(posedge clk)
    (!rst && !wr_ok && !rd_ok) |=> (count_q == $past(count_q)));

  c_count_full: cover property (@(posedge clk) !rst && full);
  c_flag_empty: cover property (@(posedge clk) !rst && empty);
  c_wr_accept: cover property (@(posedge clk) !rst && wr_ok);
  c_rd_accept: cover property (@(posedge clk) !rst && rd_ok);
  c_rejected_only: cover property (@(posedge clk) !rst && (wr_en || rd_en) && !wr_ok && !rd_ok);

endmodule

// File: tb/tb_param_sync_fifo.sv
// Scoreboard bench for param_sync_fifo: one registered-read instance and one FWFT instance.
module tb_param_sync_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Registered-read instance
  logic        r_rst, r_wr_en, r_rd_en, r_clr_err;
  logic [15:0] r_data_in, r_data_out;
  logic        r_rd_valid, r_wr_ack, r_overflow, r_underflow, r_ovf_sticky, r_udf_sticky;
  logic        r_full, r_empty, r_af, r_ae;
  logic [3:0]  r_count;

  // First-word-fall-through instance
  logic        f_rst, f_wr_en, f_rd_en, f_clr_err;
  logic [15:0] f_data_in, f_data_out;
  logic        f_rd_valid, f_wr_ack, f_overflow, f_underflow, f_ovf_sticky, f_udf_sticky;
  logic        f_full, f_empty, f_af, f_ae;
  logic [3:0]  f_count;

  param_sync_fifo #(.DATA_W(16), .DEPTH(8), .AF_THRESH(7), .AE_THRESH(1), .FWFT(0)) u_reg (
    .clk(clk), .rst(r_rst), .wr_en(r_wr_en), .data_in(r_data_in), .rd_en(r_rd_en),
    .clr_err(r_clr_err), .data_out(r_data_out), .rd_valid(r_rd_valid), .wr_ack(r_wr_ack),
    .overflow(r_overflow), .underflow(r_underflow), .ovf_sticky(r_ovf_sticky),
    .udf_sticky(r_udf_sticky), .full(r_full), .empty(r_empty), .almostfull(r_af),
    .almostempty(r_ae), .count(r_count)
  );

  param_sync_fifo #(.DATA_W(16), .DEPTH(8), .AF_THRESH(7), .AE_THRESH(1), .FWFT(1)) u_fwft (
    .clk(clk), .rst(f_rst), .wr_en(f_wr_en), .data_in(f_data_in), .rd_en(f_rd_en),
    .clr_err(f_clr_err), .data_out(f_data_out), .rd_valid(f_rd_valid), .wr_ack(f_wr_ack),
    .overflow(f_overflow), .underflow(f_underflow), .ovf_sticky(f_ovf_sticky),
    .udf_sticky(f_udf_sticky), .full(f_full), .empty(f_empty), .almostfull(f_af),
    .almostempty(f_ae), .count(f_count)
  );

  logic [15:0] mq[$];
  logic [15:0] fq[$];
  logic [15:0] last_out;
  logic        ovf_s, udf_s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic r_flags(input string tag);
    int n;
    n = mq.size();
    chk({tag, ".count"}, r_count, n);
    chk({tag, ".full"}, r_full, n == 8);
    chk({tag, ".empty"}, r_empty, n == 0);
    chk({tag, ".afull"}, r_af, n >= 7);
    chk({tag, ".aempty"}, r_ae, n <= 1);
  endtask

  task automatic r_cycle(input logic wr, input logic [15:0] din, input logic rd, input logic clr);
    int   n;
    logic wok, rok;
    n   = mq.size();
    wok = wr && (n < 8);
    rok = rd && (n > 0);
    r_wr_en = wr; r_data_in = din; r_rd_en = rd; r_clr_err = clr;
    @(posedge clk); #1;
    r_wr_en = 1'b0; r_rd_en = 1'b0; r_clr_err = 1'b0;
    ovf_s = (wr && !wok) || (ovf_s && !clr);
    udf_s = (rd && !rok) || (udf_s && !clr);
    if (rok) last_out = mq.pop_front();
    if (wok) mq.push_back(din);
    chk("wr_ack", r_wr_ack, wok);
    chk("overflow", r_overflow, wr && !wok);
    chk("underflow", r_underflow, rd && !rok);
    chk("rd_valid", r_rd_valid, rok);
    chk("data_out", r_data_out, last_out);
    chk("ovf_sticky", r_ovf_sticky, ovf_s);
    chk("udf_sticky", r_udf_sticky, udf_s);
    r_flags("r");
  endtask

  task automatic r_reset(input logic wr);
    r_rst = 1'b1; r_wr_en = wr; r_data_in = 16'hDEAD; r_rd_en = 1'b0; r_clr_err = 1'b0;
    @(posedge clk); #1;
    r_rst = 1'b0; r_wr_en = 1'b0;
    mq.delete();
    ovf_s = 1'b0; udf_s = 1'b0; last_out = '0;
    chk("rst.data_out", r_data_out, 0);
    chk("rst.rd_valid", r_rd_valid, 0);
    chk("rst.pulses", {r_wr_ack, r_overflow, r_underflow}, 0);
    chk("rst.sticky", {r_ovf_sticky, r_udf_sticky}, 0);
    r_flags("rst");
  endtask

  task automatic f_cycle(input logic wr, input logic [15:0] din, input logic rd);
    int   n;
    logic wok, rok;
    n   = fq.size();
    wok = wr && (n < 8);
    rok = rd && (n > 0);
    f_wr_en = wr; f_data_in = din; f_rd_en = rd;
    @(posedge clk); #1;
    f_wr_en = 1'b0; f_rd_en = 1'b0;
    if (rok) void'(fq.pop_front());
    if (wok) fq.push_back(din);
    chk("f.wr_ack", f_wr_ack, wok);
    chk("f.underflow", f_underflow, rd && !rok);
    chk("f.rd_valid", f_rd_valid, fq.size() > 0);
    chk("f.count", f_count, fq.size());
    chk("f.empty", f_empty, fq.size() == 0);
    if (fq.size() > 0) chk("f.data_out", f_data_out, fq[0]);
  endtask

  initial begin
    r_rst = 1'b1; r_wr_en = 1'b0; r_rd_en = 1'b0; r_clr_err = 1'b0; r_data_in = '0;
    f_rst = 1'b1; f_wr_en = 1'b0; f_rd_en = 1'b0; f_clr_err = 1'b0; f_data_in = '0;
    ovf_s = 1'b0; udf_s = 1'b0; last_out = '0;
    repeat (2) @(posedge clk);
    #1;

    r_reset(1'b0);

    // Fill to full, then one write too many.
    for (int i = 1; i <= 8; i++) r_cycle(1'b1, 16'(i), 1'b0, 1'b0);
    r_cycle(1'b1, 16'h0009, 1'b0, 1'b0);

    // Drain in order, then one read too many.
    for (int i = 0; i < 9; i++) r_cycle(1'b0, '0, 1'b1, 1'b0);

    // Simultaneous write+read at full and at empty.
    for (int i = 0; i < 8; i++) r_cycle(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0);
    r_cycle(1'b1, 16'h0055, 1'b1, 1'b0);
    repeat (7) r_cycle(1'b0, '0, 1'b1, 1'b0);
    r_cycle(1'b1, 16'h0066, 1'b1, 1'b0);
    r_cycle(1'b0, '0, 1'b1, 1'b0);

    // Steady-state streaming at count=4 across pointer wrap.
    for (int i = 0; i < 4; i++) r_cycle(1'b1, 16'h0A00 + 16'(i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) r_cycle(1'b1, 16'($urandom_range(0, 65535)), 1'b1, 1'b0);
    repeat (4) r_cycle(1'b0, '0, 1'b1, 1'b0);

    // Reset mid-operation with a write pending.
    for (int i = 0; i < 5; i++) r_cycle(1'b1, 16'h0B00 + 16'(i), 1'b0, 1'b0);
    r_reset(1'b1);

    // Sticky flags: set, set-wins-over-clear, then clear.
    r_cycle(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) r_cycle(1'b1, 16'h0C00 + 16'(i), 1'b0, 1'b0);
    r_cycle(1'b1, 16'h0CFF, 1'b0, 1'b0);
    r_cycle(1'b1, 16'h0CFE, 1'b0, 1'b1);
    r_cycle(1'b0, '0, 1'b0, 1'b1);

    // FWFT instance.
    chk("f.rst.empty", f_empty, 1);
    chk("f.rst.data_out", f_data_out, 0);
    chk("f.rst.rd_valid", f_rd_valid, 0);
    f_rst = 1'b0;
    f_cycle(1'b1, 16'hABCD, 1'b0);
    f_cycle(1'b1, 16'h1234, 1'b0);
    f_cycle(1'b0, '0, 1'b1);
    f_cycle(1'b0, '0, 1'b1);
    f_cycle(1'b0, '0, 1'b1);
    f_cycle(1'b1, 16'h5A5A, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
